// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, deserialises 11-bit
// frames, checks start/parity/stop and folds break sequences into a held make code.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT        = 50000,
  parameter int unsigned RELEASE_CLEARS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] ps2Code,
  output logic       codeValid,
  output logic       frameErr
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [7:0]      filt_cnt_q, filt_cnt_d;
  logic            filt_clk_q, filt_clk_d;
  logic            fall;
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            ok_q, ok_d;
  logic            brk_q, brk_d;
  logic [7:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_clk_d = filt_clk_q;
    fall       = 1'b0;
    if (clk_s2_q == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_s2_q;
      filt_cnt_d = '0;
      fall       = filt_clk_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 8'd1;
    end

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    valid_d   = 1'b0;
    code_d    = code_q;
    brk_d     = brk_q;

    // A frame accepted on the previous edge is interpreted one cycle later.
    if (ok_q) begin
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        brk_d = brk_q;
      end else if (brk_q) begin
        brk_d   = 1'b0;
        valid_d = 1'b1;
        if (RELEASE_CLEARS != 0) code_d = 8'h00;
      end else begin
        code_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    if (state_q == StIdle || fall) tmo_d = '0;
    else                            tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (dat_s2_q && ((^shift_q) ^ par_q)) ok_d  = 1'b1;
          else                                  err_d = 1'b1;
        end
      end
    endcase

    if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT - 1)) begin
      state_d = StIdle;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ok_q       <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= ps2Clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2Data;
      dat_s2_q   <= dat_s1_q;
      filt_cnt_q <= filt_cnt_d;
      filt_clk_q <= filt_clk_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ok_q       <= ok_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign ps2Code   = code_q;
  assign codeValid = valid_q;
  assign frameErr  = err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized frames against a behavioural keyboard-protocol model.
module tb_ps2_receiver;

  localparam int unsigned FL  = 4;
  localparam int unsigned TMO = 400;
  localparam int          H   = 16;

  logic       clk, reset, ps2Clk, ps2Data;
  logic [7:0] ps2Code;
  logic       codeValid, frameErr;

  ps2_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT       (TMO),
    .RELEASE_CLEARS(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2Clk   (ps2Clk),
    .ps2Data  (ps2Data),
    .ps2Code  (ps2Code),
    .codeValid(codeValid),
    .frameErr (frameErr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nvalid, nerr, vcyc, ecyc;
  int nboth    = 0;
  int last_fall_cyc;

  logic [7:0] m_code;
  bit         m_brk;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (codeValid) begin nvalid++; vcyc = cyc; end
      if (frameErr)  begin nerr++;   ecyc = cyc; end
      if (codeValid && frameErr) nboth++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bits go out LSB first; an optional short low glitch sits in some high phases.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[i];
      if (glitch && i >= 2 && i <= 6) begin
        wait_cyc(H / 2);
        ps2Clk = 1'b0;
        wait_cyc(FL - 1);
        ps2Clk = 1'b1;
        wait_cyc(H - H / 2 - (FL - 1));
      end else begin
        wait_cyc(H);
      end
      ps2Clk        = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(H);
      ps2Clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input bit glitch);
    int exp_valid, exp_err;
    exp_valid = 0;
    exp_err   = 0;
    if (bad_par || bad_stop) begin
      exp_err = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      exp_valid = 0;
    end else if (m_brk) begin
      m_brk     = 1'b0;
      m_code    = 8'h00;
      exp_valid = 1;
    end else begin
      m_code    = b;
      exp_valid = 1;
    end
    nvalid = 0;
    nerr   = 0;
    send_bits(mk_frame(b, bad_par, bad_stop), 11, glitch);
    wait_cyc(30);
    check($sformatf("%s_valid_cycles", tag), nvalid, exp_valid);
    check($sformatf("%s_err_cycles", tag), nerr, exp_err);
    check($sformatf("%s_code", tag), ps2Code, m_code);
    if (exp_valid == 1) check($sformatf("%s_latency", tag), vcyc - last_fall_cyc, 3 + FL);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         bp, bs;

    reset   = 1'b1;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    m_code  = 8'h00;
    m_brk   = 1'b0;
    wait_cyc(5);
    check("reset_code", ps2Code, 8'h00);
    check("reset_valid", codeValid, 1'b0);
    check("reset_err", frameErr, 1'b0);
    reset = 1'b0;
    wait_cyc(10);

    run_frame("make16", 8'h16, 1'b0, 1'b0, 1'b0);
    run_frame("badpar26", 8'h26, 1'b1, 1'b0, 1'b0);
    run_frame("make2d", 8'h2D, 1'b0, 1'b0, 1'b0);
    run_frame("break_f0", 8'hF0, 1'b0, 1'b0, 1'b0);
    run_frame("release2d", 8'h2D, 1'b0, 1'b0, 1'b0);
    run_frame("badstop", 8'h5A, 1'b0, 1'b1, 1'b0);

    // Clock stalls after four data bits.
    nvalid = 0;
    nerr   = 0;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5, 1'b0);
    wait_cyc(TMO + 40);
    check("timeout_err_cycles", nerr, 1);
    check("timeout_valid_cycles", nvalid, 0);
    check("timeout_latency", ecyc - last_fall_cyc, 2 + FL + TMO);
    run_frame("after_tmo_1e", 8'h1E, 1'b0, 1'b0, 1'b0);

    run_frame("glitch34", 8'h34, 1'b0, 1'b0, 1'b1);

    // Lone clock pulse with data high is a bad start bit.
    nvalid = 0;
    nerr   = 0;
    send_bits(11'h001, 1, 1'b0);
    wait_cyc(20);
    check("badstart_err_cycles", nerr, 1);
    check("badstart_code", ps2Code, m_code);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 6, 1'b0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    check("midreset_code", ps2Code, 8'h00);
    check("midreset_valid", codeValid, 1'b0);
    check("midreset_err", frameErr, 1'b0);
    wait_cyc(3);
    reset  = 1'b0;
    m_code = 8'h00;
    m_brk  = 1'b0;
    wait_cyc(20);
    run_frame("after_reset_32", 8'h32, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else             b = 8'($urandom);
      bp = 1'b0;
      bs = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) bp = 1'b1;
        else                           bs = 1'b1;
      end
      run_frame($sformatf("rand%0d", k), b, bp, bs, 1'($urandom_range(0, 1)));
    end

    check("valid_err_overlap", nboth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
